// File: rtl/fpga_cfg_pkg.sv
// fpga_cfg_pkg: shared state encoding and configuration field layout for logic tiles
package fpga_cfg_pkg;
  typedef enum logic [1:0] {UNCONF, SHIFT, ACTIVE} state_e;
  localparam int LUT_LSB = 0;
  function automatic int cfg_bits(input int k);
    return (1 << k) + 2;
  endfunction
  function automatic int reg_sel_idx(input int k);
    return 1 << k;
  endfunction
  function automatic int init_idx(input int k);
    return (1 << k) + 1;
  endfunction
endpackage

// File: rtl/lut_mux.sv
// lut_mux: 2^K:1 selection mux, sel picks one bit of data
module lut_mux #(
  parameter int K = 4
) (
  input  logic [2**K-1:0] data,
  input  logic [K-1:0]    sel,
  output logic            y
);
  assign y = data[sel];
endmodule

// File: rtl/cfg_logic_tile.sv
// cfg_logic_tile: K-input LUT tile with optional output flop and scan-loaded, atomically committed config
module cfg_logic_tile
  import fpga_cfg_pkg::*;
#(
  parameter int K = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [K-1:0] in,
  input  logic         ce,
  output logic         out,
  input  logic         cfg_en,
  input  logic         cfg_in,
  output logic         cfg_out,
  input  logic         cfg_commit,
  output logic         cfg_done,
  output logic         cfg_err
);
  localparam int CFG_BITS = cfg_bits(K);
  localparam int N = 2**K;
  localparam int RS = reg_sel_idx(K);
  localparam int IV = init_idx(K);
  localparam int CW = $clog2(CFG_BITS + 2);
  logic [CFG_BITS-1:0] shadow_q, shadow_d, active_q, active_d;
  logic [CW-1:0] cnt_q, cnt_d;
  state_e state_q, state_d;
  logic valid_q, valid_d, q_q, q_d, done_q, done_d, err_q, err_d;
  logic shift, commit, ok, run, lut_o;
  assign shift  = cfg_en & ~cfg_commit;
  assign commit = cfg_commit & ~cfg_en;
  assign ok     = commit && state_q == SHIFT && cnt_q == CW'(CFG_BITS);
  // the old function keeps running while a new config streams in
  assign run    = state_q == ACTIVE || (state_q == SHIFT && valid_q);
  lut_mux #(.K(K)) u_lut_mux (
    .data(active_q[LUT_LSB +: N]),
    .sel (in),
    .y   (lut_o)
  );
  always_comb begin
    shadow_d = shift ? {cfg_in, shadow_q[CFG_BITS-1:1]} : shadow_q;
    active_d = ok ? shadow_q : active_q;
    valid_d  = valid_q | ok;
    cnt_d    = cfg_commit ? '0 : (shift && cnt_q != CW'(CFG_BITS + 1)) ? cnt_q + 1'b1 : cnt_q;
    done_d   = shift ? 1'b0 : ok ? 1'b1 : done_q;
    err_d    = (cfg_commit & ~ok) ? 1'b1 : shift ? 1'b0 : err_q;
    q_d      = ok ? shadow_q[IV] : !run ? 1'b0 : ce ? lut_o : q_q;
    state_d  = shift ? SHIFT
             : (commit && state_q == SHIFT) ? ((ok || valid_q) ? ACTIVE : UNCONF)
             : state_q;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      state_q  <= UNCONF;
      valid_q  <= 1'b0;
      q_q      <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      valid_q  <= valid_d;
      q_q      <= q_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end
  assign out      = run & (active_q[RS] ? q_q : lut_o);
  assign cfg_out  = shadow_q[0];
  assign cfg_done = done_q;
  assign cfg_err  = err_q;
endmodule

// File: tb/tb_cfg_logic_tile.sv
// tb_cfg_logic_tile: directed and random scan/commit/datapath checks against a bit-queue reference model
module tb_cfg_logic_tile;
  localparam int K = 4;
  localparam int CB = 18;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [K-1:0] tin;
  logic ce, cfg_en, cfg_in, cfg_commit;
  logic out, cfg_out, cfg_done, cfg_err;
  int nvec = 0;
  int nerr = 0;
  bit sh[$];
  int cnt;
  bit [15:0] m_lut;
  bit m_rsel, m_valid, m_q, m_done, m_err, m_pend;
  cfg_logic_tile #(.K(K)) dut (
    .clock(clock), .reset_n(reset_n), .in(tin), .ce(ce), .out(out),
    .cfg_en(cfg_en), .cfg_in(cfg_in), .cfg_out(cfg_out),
    .cfg_commit(cfg_commit), .cfg_done(cfg_done), .cfg_err(cfg_err)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic got, input logic exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit m_out();
    return m_valid ? (m_rsel ? m_q : m_lut[tin]) : 1'b0;
  endfunction
  task automatic model_reset();
    sh = {};
    repeat (CB) sh.push_back(1'b0);
    cnt = 0; m_lut = '0; m_rsel = 0; m_valid = 0; m_q = 0; m_done = 0; m_err = 0; m_pend = 0;
  endtask
  // a commit succeeds only after exactly CB shifts since the last commit attempt
  task automatic model_edge();
    bit sft, cm, ok, lo;
    sft = cfg_en && !cfg_commit;
    cm  = cfg_commit && !cfg_en;
    ok  = cm && m_pend && cnt == CB;
    lo  = m_lut[tin];
    if (ok) m_q = sh[CB-1];
    else if (!m_valid) m_q = 0;
    else if (ce) m_q = lo;
    if (ok) begin
      for (int i = 0; i < 16; i++) m_lut[i] = sh[i];
      m_rsel = sh[16]; m_valid = 1; m_done = 1;
    end
    if (cfg_commit && !ok) m_err = 1;
    if (cfg_commit) cnt = 0;
    if (cm) m_pend = 0;
    if (sft) begin
      void'(sh.pop_front());
      sh.push_back(cfg_in);
      if (cnt < CB + 1) cnt++;
      m_pend = 1; m_done = 0; m_err = 0;
    end
  endtask
  task automatic step();
    @(negedge clock);
    chk("out", out, m_out());
    chk("cfg_out", cfg_out, sh[0]);
    chk("cfg_done", cfg_done, m_done);
    chk("cfg_err", cfg_err, m_err);
    @(posedge clock);
    model_edge();
    #1;
  endtask
  task automatic send_bits(input logic [19:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      cfg_en = 1'b1; cfg_in = v[i];
      step();
    end
    cfg_en = 1'b0; cfg_in = 1'b0;
  endtask
  task automatic do_commit();
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
  endtask
  initial begin
    logic [19:0] p;
    int lens[5];
    lens = '{17, 18, 18, 18, 19};
    tin = '0; ce = 0; cfg_en = 0; cfg_in = 0; cfg_commit = 0;
    model_reset();
    #2;
    chk("rst_out", out, 1'b0);
    chk("rst_cfg_out", cfg_out, 1'b0);
    chk("rst_done", cfg_done, 1'b0);
    chk("rst_err", cfg_err, 1'b0);
    #10 reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tin = 4'($urandom); ce = 1'($urandom);
      step();
      chk("unconf_out", out, 1'b0);
    end
    // AND4, combinational
    send_bits({4'b0000, 16'h8000}, CB);
    do_commit();
    chk("and4_done", cfg_done, 1'b1);
    tin = 4'hF; #1 chk("and4_f", out, 1'b1);
    tin = 4'hE; #1 chk("and4_e", out, 1'b0);
    step();
    // short and long shifts must be rejected and leave AND4 running
    send_bits({4'b0011, 16'h6996}, 17);
    do_commit();
    tin = 4'hF; #1;
    chk("short_err", cfg_err, 1'b1);
    chk("short_keep", out, 1'b1);
    send_bits({4'b0011, 16'h6996}, 19);
    do_commit();
    #1;
    chk("long_err", cfg_err, 1'b1);
    chk("long_keep", out, 1'b1);
    send_bits(20'h1, 1);
    chk("err_clear", cfg_err, 1'b0);
    do_commit();
    // live reconfigure to combinational XOR4
    tin = 4'hF;
    for (int i = 0; i < CB; i++) begin
      p = {4'b0000, 16'h6996};
      cfg_en = 1'b1; cfg_in = p[i];
      step();
      chk("live_out", out, 1'b1);
    end
    cfg_en = 1'b0;
    do_commit();
    chk("live_new", out, 1'b0);
    chk("live_done", cfg_done, 1'b1);
    // registered XOR4 with init 1
    send_bits({4'b0011, 16'h6996}, CB);
    do_commit();
    chk("xor_init", out, 1'b1);
    ce = 1'b1; tin = 4'b0011;
    step();
    chk("xor_ce", out, 1'b0);
    ce = 1'b0; tin = 4'b0001;
    step();
    chk("xor_hold", out, 1'b0);
    // collision: no shift, error flagged
    cfg_en = 1'b1; cfg_commit = 1'b1; cfg_in = 1'b1;
    step();
    cfg_en = 1'b0; cfg_commit = 1'b0; cfg_in = 1'b0;
    chk("col_err", cfg_err, 1'b1);
    chk("col_shadow", cfg_out, 1'b0);
    // chaining: the shadow streams P back out in order
    p = 20'($urandom);
    send_bits(p, CB);
    chk("chain_0", cfg_out, p[0]);
    for (int i = 1; i < CB; i++) begin
      cfg_en = 1'b1; cfg_in = 1'b0;
      step();
      chk("chain_k", cfg_out, p[i]);
    end
    cfg_en = 1'b0;
    do_commit();
    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        p = 20'($urandom);
        send_bits(p, lens[$urandom_range(0, 4)]);
        do_commit();
      end else begin
        for (int c = 0; c < 10; c++) begin
          tin = 4'($urandom); ce = 1'($urandom);
          cfg_commit = ($urandom_range(0, 15) == 0);
          cfg_en = ($urandom_range(0, 15) == 0);
          cfg_in = 1'($urandom);
          step();
        end
        cfg_en = 1'b0; cfg_commit = 1'b0;
      end
    end
    // asynchronous reset mid-run with an active function
    send_bits({4'b0000, 16'hFFFF}, CB);
    do_commit();
    tin = 4'h3; #1 chk("pre_rst_out", out, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst_out", out, 1'b0);
    chk("arst_cfg_out", cfg_out, 1'b0);
    chk("arst_done", cfg_done, 1'b0);
    chk("arst_err", cfg_err, 1'b0);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tin = 4'($urandom); ce = 1'b1;
      step();
      chk("unconf_out2", out, 1'b0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/cfg_logic_tile.md
Name: cfg_logic_tile

Overview:
- Next-generation fabric logic tile with a K-input LUT (parametrised) and an optional output flip-flop with clock enable and programmable init value.
- Configuration is loaded over a serial scan chain into a shadow register, then committed atomically into the active configuration. The tile keeps running its current function while a new configuration is shifted in.
- Tiles daisy-chain via cfg_in/cfg_out to form the fabric configuration path.

Parameters:
- K, 4, LUT input count (2..6); LUT size 2^K bits.
- CFG_BITS, 2^K+2, derived, not overridable: LUT bits + reg_sel + init_val.

Ports:
- clock  in  1  rising-edge clock for datapath and config logic
- reset_n  in  1  asynchronous active-low reset
- in  in  K  LUT select inputs; in[0] is the LSB of the LUT index
- ce  in  1  flip-flop clock enable
- out  out  1  tile output
- cfg_en  in  1  shift one config bit this cycle
- cfg_in  in  1  serial config data in
- cfg_out  out  1  serial config data out (shadow[0]), for chaining
- cfg_commit  in  1  single-cycle pulse requesting transfer of shadow to active
- cfg_done  out  1  high while a valid committed config is active and no shift has begun since
- cfg_err  out  1  sticky commit-error flag

Behaviour:
- Reset (async, reset_n=0) clears the following immediately:
  - shadow=0, active=0, bit count=0, ff q=0, state=UNCONF.
  - out=0, cfg_out=0, cfg_done=0, cfg_err=0.
- Config layout, identical in shadow and active:
  - [2^K-1:0] LUT truth table.
  - [2^K] reg_sel.
  - [2^K+1] init_val.
- Shift behaviour:
  - On a clock edge with cfg_en=1 and cfg_commit=0: shadow <= {cfg_in, shadow[CFG_BITS-1:1]}.
  - The first bit streamed in lands in shadow[0] after CFG_BITS shifts. Stream order is LUT bit 0 first and init_val last.
- Bit count:
  - Increments per shift and saturates at CFG_BITS+1.
  - Resets to 0 on every commit attempt, successful or not.
- FSM states:
  - UNCONF: after reset; out forced to 0.
  - SHIFT: entered on the first cfg_en; remembers whether a valid config is active.
  - ACTIVE: valid config in use.
- FSM transitions:
  - Any state plus cfg_en goes to SHIFT. cfg_done goes to 0 on that edge, and cfg_err is cleared on that edge.
  - SHIFT plus cfg_commit with count==CFG_BITS:
    - active <= shadow; q <= shadow init_val bit; cfg_done <= 1; go to ACTIVE.
  - SHIFT plus cfg_commit with count!=CFG_BITS (short shift or overshift):
    - cfg_err <= 1; active and q unchanged.
    - Return to ACTIVE if a valid config existed before, else UNCONF.
  - cfg_commit in UNCONF or ACTIVE with no shift since the last commit: cfg_err <= 1, no other change.
- cfg_en and cfg_commit in the same cycle: no shift, no commit, cfg_err <= 1, count reset to 0.
- Datapath in ACTIVE, or in SHIFT with a prior valid config:
  - lut_o = active_lut[in], combinational.
  - On a clock edge with ce=1: q <= lut_o. With ce=0, q holds.
  - out = reg_sel ? q : lut_o.
  - With reg_sel=0, output latency from in to out is combinational. With reg_sel=1, latency is one cycle.
- In UNCONF, or in SHIFT without a prior valid config: out=0 and q is held at 0.
- Commit edge:
  - q loads init_val regardless of ce.
  - The new function is visible at out from that edge onward.
- Shadow contents persist after commit; the next configuration overwrites them by shifting.

Decomposition:
- Package fpga_cfg_pkg holds:
  - The state enum (UNCONF/SHIFT/ACTIVE).
  - Config-field offset functions of K: LUT_LSB=0, REG_SEL_IDX=2^K, INIT_IDX=2^K+1.
  - The CFG_BITS function.
- Sub-module lut_mux: parametrised 2^K:1 selection mux, the generalisation of the 4:1 mux. Its ports are data[2^K-1:0], sel[K-1:0], and y. It is reused by the future routing-box generation.

Test Plan:
All scenarios use K=4, CFG_BITS=18.
- Reset: assert reset_n=0 mid-run -> out=0, cfg_out=0, cfg_done=0, cfg_err=0 immediately, without waiting for a clock edge. Any in/ce activity in UNCONF -> out stays 0.
- AND4 combinational:
  - Shift LUT=16'h8000, reg_sel=0, init=0 (18 bits), then commit -> cfg_done=1 after the commit edge.
  - in=4'hF -> out=1 in the same cycle; in=4'hE -> out=0.
- XOR4 registered:
  - LUT=16'h6996, reg_sel=1, init=1; commit -> out=1 right after the commit edge.
  - ce=1, in=4'b0011 -> out=0 after the next edge.
  - ce=0, in=4'b0001 -> out holds 0.
- Bad commit:
  - Shift 17 bits, then commit -> cfg_err=1 and the prior AND4 function is still seen at out.
  - Repeat with 19 bits -> same.
  - A new cfg_en clears cfg_err.
- Live reconfigure:
  - While AND4 is active, shift XOR4 and hold in=4'hF -> out stays 1 throughout the shift.
  - After the commit edge -> out=0 (XOR of 4'hF).
- Collision and chaining:
  - cfg_en=cfg_commit=1 in the same cycle -> cfg_err=1, shadow unchanged.
  - After 18 shifts of pattern P, cfg_out equals P's first bit. Each further shift emits P's subsequent bits in order.
